// File: rtl/rr_burst_arbiter.sv
// Round-robin burst-locking arbiter: eight requesters share one {id, offset} beat channel.
// Define RR_BURST_ARB_BACK2BACK_EN to grant the next burst in the last-beat cycle (zero bubble).
module rr_burst_arbiter #(
  parameter int N_REQ = 8,
  parameter int ID_W  = 3,
  parameter int OFF_W = 3,
  localparam int SRC_W = $clog2(N_REQ)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         io_req_valid,
  output logic [N_REQ-1:0]         io_req_ready,
  input  logic [N_REQ*ID_W-1:0]    io_req_id,
  input  logic [N_REQ*OFF_W-1:0]   io_req_len,
  output logic                     io_out_valid,
  input  logic                     io_out_ready,
  output logic [ID_W-1:0]          io_out_bits_id,
  output logic [OFF_W-1:0]         io_out_bits_offset,
  output logic                     io_out_bits_last,
  output logic [SRC_W-1:0]         io_out_bits_src,
  output logic                     io_busy
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t                          state_r;
  logic [SRC_W-1:0]                ptr_r;
  logic [SRC_W-1:0]                src_r;
  logic [ID_W-1:0]                 id_r;
  logic [OFF_W-1:0]                len_r;
  logic [OFF_W-1:0]                off_r;

  logic [N_REQ-1:0][ID_W-1:0]      ids_s;
  logic [N_REQ-1:0][OFF_W-1:0]     lens_s;
  logic [SRC_W-1:0]                winner_s;
  logic                            found_s;
  logic                            last_s;
  logic                            grant_en_s;
  logic                            accept_s;

  assign ids_s  = io_req_id;
  assign lens_s = io_req_len;

  // Round-robin search: first valid requester at or after ptr, wrapping modulo N_REQ.
  always_comb begin
    logic [SRC_W-1:0] cand;
    found_s  = 1'b0;
    winner_s = {SRC_W{1'b0}};
    for (int k = 0; k < N_REQ; k++) begin
      cand = ptr_r + SRC_W'(k);
      if (!found_s && io_req_valid[cand]) begin
        found_s  = 1'b1;
        winner_s = cand;
      end else begin
        found_s  = found_s;
      end
    end
  end

  assign last_s = (state_r == BURST) && (off_r == len_r);

  // Decide whether a new descriptor may be accepted this cycle.
  always_comb begin
    grant_en_s = 1'b0;
    if (!reset) begin
      grant_en_s = 1'b0;
    end else if (state_r == IDLE) begin
      grant_en_s = 1'b1;
    end else begin
`ifdef RR_BURST_ARB_BACK2BACK_EN
      grant_en_s = last_s & io_out_ready;
`else
      grant_en_s = 1'b0;
`endif
    end
  end

  assign accept_s     = found_s & grant_en_s;
  assign io_req_ready = accept_s ? ({{(N_REQ-1){1'b0}}, 1'b1} << winner_s) : {N_REQ{1'b0}};

  assign io_out_valid       = (state_r == BURST);
  assign io_busy            = (state_r == BURST);
  assign io_out_bits_id     = id_r;
  assign io_out_bits_offset = off_r;
  assign io_out_bits_src    = src_r;
  assign io_out_bits_last   = last_s;

  // Burst FSM: latch the winning descriptor, then step the offset on each accepted beat.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r <= IDLE;
      ptr_r   <= {SRC_W{1'b0}};
      src_r   <= {SRC_W{1'b0}};
      id_r    <= {ID_W{1'b0}};
      len_r   <= {OFF_W{1'b0}};
      off_r   <= {OFF_W{1'b0}};
    end else if (accept_s) begin
      state_r <= BURST;
      src_r   <= winner_s;
      id_r    <= ids_s[winner_s];
      len_r   <= lens_s[winner_s];
      off_r   <= {OFF_W{1'b0}};
      ptr_r   <= winner_s + SRC_W'(1'b1);
    end else begin
      case (state_r)
        IDLE: begin
          state_r <= IDLE;
        end
        BURST: begin
          if (io_out_ready) begin
            if (last_s) begin
              state_r <= IDLE;
            end else begin
              off_r <= off_r + OFF_W'(1'b1);
            end
          end else begin
            state_r <= BURST;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Self-checking bench for rr_burst_arbiter: directed scenarios plus randomized traffic
// against a transaction-level reference model.
module tb_rr_burst_arbiter;

  localparam int N = 8;
`ifdef RR_BURST_ARB_BACK2BACK_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N-1:0][2:0] req_id  = '0;
  logic [N-1:0][2:0] req_len = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [2:0]      out_id;
  logic [2:0]      out_off;
  logic            out_last;
  logic [2:0]      out_src;
  logic            busy;

  int errors = 0;
  int checks = 0;

  rr_burst_arbiter dut (
    .clock              (clock),
    .reset              (reset),
    .io_req_valid       (req_valid),
    .io_req_ready       (req_ready),
    .io_req_id          (req_id),
    .io_req_len         (req_len),
    .io_out_valid       (out_valid),
    .io_out_ready       (out_ready),
    .io_out_bits_id     (out_id),
    .io_out_bits_offset (out_off),
    .io_out_bits_last   (out_last),
    .io_out_bits_src    (out_src),
    .io_busy            (busy)
  );

  always #5 clock = ~clock;

  task automatic cyc();
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b0; req_valid = '0; out_ready = 1'b1;
    cyc(); cyc();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; req_valid = '1; out_ready = 1'b1;
    cyc(); cyc(); #1;
    checks++;
    if ({out_valid, busy, out_last, out_id, out_off, out_src, req_ready} !== 18'd0) begin
      errors++;
      $display("FAIL reset_state: got v=%b busy=%b last=%b id=%0d off=%0d src=%0d ready=%b, expected all zero",
               out_valid, busy, out_last, out_id, out_off, out_src, req_ready);
    end
    req_valid = '0;
    reset = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 8'b0000_0100; req_id[2] = 3'd5; req_len[2] = 3'd3;
    #1;
    checks++;
    if (req_ready !== 8'b0000_0100) begin
      errors++; $display("FAIL single_grant: ready=%b expected 00000100", req_ready);
    end
    cyc();
    req_valid = '0;
    for (int b = 0; b < 4; b++) begin
      #1;
      checks++;
      if ({out_valid, busy, out_id, out_off, out_src, out_last} !== {1'b1, 1'b1, 3'd5, 3'(b), 3'd2, (b == 3)}) begin
        errors++;
        $display("FAIL single_beat%0d: v=%b busy=%b id=%0d off=%0d src=%0d last=%b, expected v=1 busy=1 id=5 off=%0d src=2 last=%0d",
                 b, out_valid, busy, out_id, out_off, out_src, out_last, b, (b == 3));
      end
      cyc();
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL single_end: out_valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_fairness();
    int beat_cyc[$];
    int beat_src[$];
    int gap;
    gap = B2B ? 1 : 2;
    do_reset();
    for (int i = 0; i < N; i++) begin
      req_id[i] = 3'(i); req_len[i] = 3'd0;
    end
    req_valid = '1;
    for (int c = 0; c < 24; c++) begin
      #1;
      if (out_valid === 1'b1) begin
        beat_cyc.push_back(c); beat_src.push_back(int'(out_src));
      end
      cyc();
    end
    req_valid = '0;
    checks++;
    if (beat_cyc.size() < 9) begin
      errors++; $display("FAIL fair_count: beats=%0d expected at least 9", beat_cyc.size());
    end
    for (int k = 0; k < 9 && k < beat_cyc.size(); k++) begin
      checks++;
      if (beat_src[k] != k % N) begin
        errors++; $display("FAIL fair_order%0d: src=%0d expected %0d", k, beat_src[k], k % N);
      end
      if (k > 0) begin
        checks++;
        if (beat_cyc[k] - beat_cyc[k-1] != gap) begin
          errors++; $display("FAIL fair_gap%0d: gap=%0d expected %0d", k, beat_cyc[k] - beat_cyc[k-1], gap);
        end
      end
    end
    do_reset();
  endtask

  task automatic test_backpressure();
    do_reset();
    req_valid = 8'b0000_0001; req_id[0] = 3'd3; req_len[0] = 3'd7;
    cyc();
    req_valid = '0;
    for (int b = 0; b < 8; b++) begin
      if (b == 4) begin
        out_ready = 1'b0;
        for (int h = 0; h < 3; h++) begin
          #1;
          checks++;
          if ({out_valid, out_id, out_off, out_src, out_last} !== {1'b1, 3'd3, 3'd4, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL bp_hold%0d: v=%b id=%0d off=%0d src=%0d last=%b expected v=1 id=3 off=4 src=0 last=0",
                     h, out_valid, out_id, out_off, out_src, out_last);
          end
          cyc();
        end
        out_ready = 1'b1;
      end
      #1;
      checks++;
      if ({out_valid, out_id, out_off, out_last} !== {1'b1, 3'd3, 3'(b), (b == 7)}) begin
        errors++;
        $display("FAIL bp_beat%0d: v=%b id=%0d off=%0d last=%b expected v=1 id=3 off=%0d last=%0d",
                 b, out_valid, out_id, out_off, out_last, b, (b == 7));
      end
      cyc();
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_end: out_valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_wraparound();
    do_reset();
    req_valid = 8'b0100_0000; req_len[6] = 3'd0;
    cyc();
    req_valid = '0;
    cyc();
    req_valid = 8'b1000_0010; req_len[1] = 3'd0; req_len[7] = 3'd0;
    #1;
    checks++;
    if (req_ready !== 8'b1000_0000) begin
      errors++; $display("FAIL wrap_first: ready=%b expected 10000000", req_ready);
    end
    cyc();
    req_valid = 8'b0000_0010;
    #1;
    checks++;
    if ({out_valid, out_src} !== {1'b1, 3'd7}) begin
      errors++; $display("FAIL wrap_beat7: v=%b src=%0d expected v=1 src=7", out_valid, out_src);
    end
    if (!B2B) begin
      cyc(); #1;
    end
    checks++;
    if (req_ready !== 8'b0000_0010) begin
      errors++; $display("FAIL wrap_second: ready=%b expected 00000010", req_ready);
    end
    cyc();
    req_valid = '0;
    #1;
    checks++;
    if ({out_valid, out_src} !== {1'b1, 3'd1}) begin
      errors++; $display("FAIL wrap_beat1: v=%b src=%0d expected v=1 src=1", out_valid, out_src);
    end
    cyc();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    req_valid = 8'b0000_0001; req_id[0] = 3'd6; req_len[0] = 3'd5;
    cyc();
    req_valid = '0;
    cyc(); cyc(); #1;
    checks++;
    if ({out_valid, out_off} !== {1'b1, 3'd2}) begin
      errors++; $display("FAIL rst_mid_pre: v=%b off=%0d expected v=1 off=2", out_valid, out_off);
    end
    reset = 1'b0;
    cyc(); #1;
    checks++;
    if ({out_valid, busy, out_last, out_id, out_off, out_src, req_ready} !== 18'd0) begin
      errors++;
      $display("FAIL rst_mid_outputs: v=%b busy=%b last=%b id=%0d off=%0d src=%0d ready=%b expected all zero",
               out_valid, busy, out_last, out_id, out_off, out_src, req_ready);
    end
    reset = 1'b1;
    req_valid = 8'b0010_1000; req_len[3] = 3'd0; req_len[5] = 3'd0;
    #1;
    checks++;
    if (req_ready !== 8'b0000_1000) begin
      errors++; $display("FAIL rst_mid_regrant: ready=%b expected 00001000", req_ready);
    end
    cyc();
    req_valid = '0;
    #1;
    checks++;
    if ({out_valid, out_src} !== {1'b1, 3'd3}) begin
      errors++; $display("FAIL rst_mid_beat: v=%b src=%0d expected v=1 src=3", out_valid, out_src);
    end
    cyc();
  endtask

  // Transaction-level model: current burst descriptor, beat position and round-robin pointer.
  task automatic test_random();
    bit       m_busy = 1'b0;
    int       m_ptr = 0, m_src = 0, m_id = 0, m_len = 0, m_off = 0;
    bit       m_last, allow;
    int       win;
    logic [N-1:0] exp_ready;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
          req_valid[i] = 1'b1;
          req_id[i]  = 3'($urandom_range(0, 7));
          req_len[i] = 3'($urandom_range(0, 7));
        end else if (req_valid[i] && $urandom_range(0, 15) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      m_last = m_busy && (m_off == m_len);
      allow  = !m_busy || (B2B && m_last && out_ready);
      win = -1;
      for (int k = 0; k < N; k++) begin
        if (win < 0 && req_valid[(m_ptr + k) % N]) win = (m_ptr + k) % N;
      end
      exp_ready = (allow && win >= 0) ? (N'(1) << win) : '0;
      checks++;
      if (req_ready !== exp_ready) begin
        errors++; $display("FAIL rand_ready c%0d: ready=%b expected %b", c, req_ready, exp_ready);
      end
      checks++;
      if ({out_valid, busy, out_last} !== {m_busy, m_busy, m_last}) begin
        errors++;
        $display("FAIL rand_ctrl c%0d: v=%b busy=%b last=%b expected v=%b busy=%b last=%b",
                 c, out_valid, busy, out_last, m_busy, m_busy, m_last);
      end
      if (m_busy) begin
        checks++;
        if ({out_id, out_off, out_src} !== {3'(m_id), 3'(m_off), 3'(m_src)}) begin
          errors++;
          $display("FAIL rand_bits c%0d: id=%0d off=%0d src=%0d expected id=%0d off=%0d src=%0d",
                   c, out_id, out_off, out_src, m_id, m_off, m_src);
        end
      end
      if (m_busy && out_ready) begin
        if (m_last) m_busy = 1'b0;
        else        m_off++;
      end
      if (exp_ready != '0) begin
        m_busy = 1'b1; m_src = win; m_id = int'(req_id[win]); m_len = int'(req_len[win]);
        m_off = 0; m_ptr = (win + 1) % N;
      end
      cyc();
      if (exp_ready != '0) req_valid[win] = 1'b0;
    end
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_wraparound();
    test_reset_mid_burst();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_burst_arbiter.md
# rr_burst_arbiter

Round-robin, burst-locking arbiter that shares the single `{id, offset}` beat channel among eight requesters. Each requester submits one burst descriptor: an id plus a beat count. The arbiter grants one requester at a time in round-robin order. It then sequences that burst onto the output as consecutive beats with an incrementing offset, and holds the lock until the last beat is accepted. It replaces fixed-priority selection where fairness and multi-beat atomicity are required.

## Interface
Parameters:
- `N_REQ`, 8, number of requesters (power of two, ≥2)
- `ID_W`, 3, id width
- `OFF_W`, 3, offset / length width; a burst carries at most 2^OFF_W beats

Ports:
- `clock`  in  1  sole clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-low reset
- `io_req_valid`  in  N_REQ  per-requester descriptor valid
- `io_req_ready`  out  N_REQ  per-requester descriptor accept (one-hot or zero)
- `io_req_id`  in  N_REQ*ID_W  packed ids; requester i is at [i*ID_W +: ID_W]
- `io_req_len`  in  N_REQ*OFF_W  packed beat count minus one; requester i is at [i*OFF_W +: OFF_W]
- `io_out_valid`  out  1  beat valid
- `io_out_ready`  in  1  beat accept from downstream
- `io_out_bits_id`  out  ID_W  id of the current burst
- `io_out_bits_offset`  out  OFF_W  beat index within the burst
- `io_out_bits_last`  out  1  current beat is the final beat
- `io_out_bits_src`  out  log2(N_REQ)  index of the granted requester
- `io_busy`  out  1  a burst is in progress

## Operation
- The FSM has two states, IDLE and BURST. Registers: `state`, `ptr`, `src`, `id_q`, `len_q`, `off_q`.
- Winner selection is combinational. The winner is the lowest index ≥ `ptr` with valid set. If none, it is the lowest index < `ptr` with valid set (wrap-around).
- IDLE behaviour:
  - If any `io_req_valid` bit is set, `io_req_ready[winner]`=1 and all other ready bits are 0.
  - On that handshake: `src`←winner, `id_q`←id[winner], `len_q`←len[winner], `off_q`←0, `ptr`←(winner+1) mod N_REQ, and state→BURST.
- BURST outputs and updates:
  - `io_out_valid`=1 and `io_busy`=1.
  - Output bits come straight from the registers. `io_out_bits_last`=(`off_q`==`len_q`).
  - On `io_out_valid & io_out_ready`: if not last, `off_q`←`off_q`+1; if last, state→IDLE.
- `io_req_ready` is all zero in BURST, except as described under Configuration.
- `len`=0 gives a single beat with offset 0 and last=1. `len`=2^OFF_W−1 gives a full burst, and `off_q` never wraps past `len_q`.
- Requesters must hold valid, id and len stable until ready. A requester may drop valid while ungranted; it is then simply not considered.
- While granted, a requester's input changes have no effect, because the descriptor is registered.
- The arbiter never abandons a burst except on reset.

## Timing
- Reset values while `reset`=0:
  - `io_out_valid`=0, `io_req_ready`=0, `io_busy`=0, `io_out_bits_last`=0.
  - `io_out_bits_id`=0, `io_out_bits_offset`=0, `io_out_bits_src`=0.
  - `ptr`=0 and state=IDLE.
- Grant latency: a descriptor accepted in cycle t produces its first beat valid in cycle t+1.
- Without backpressure, a burst of L beats occupies cycles t+1 .. t+L.
- Backpressure: while `io_out_ready`=0, all output bits hold stable and `off_q` does not advance.
- Without the Configuration macro, the final-beat handshake cycle is followed by one IDLE cycle. The next grant happens in that IDLE cycle, so the next first beat appears 2 cycles after the previous last beat.
- Reset mid-burst: the burst is dropped. `io_out_valid`=0 in the cycle after `reset` is sampled low, and `ptr` returns to 0.
- `io_req_ready` depends combinationally on `io_req_valid` and state. There is no path from `io_out_ready` to `io_req_ready` except as described under Configuration.

## Configuration
- Macro: `RR_BURST_ARB_BACK2BACK_EN`.
- Defined:
  - In the cycle where the last beat handshakes (BURST, last=1, `io_out_ready`=1), the winner, selected against the current `ptr`, gets `io_req_ready` in the same cycle.
  - Its descriptor loads directly, and state stays BURST, giving zero bubble between bursts.
  - If no requester is valid in that cycle, state→IDLE.
  - This creates a combinational path from `io_out_ready` to `io_req_ready`.
- Undefined: one IDLE cycle between bursts, as specified under Timing, and no `io_out_ready`→`io_req_ready` path.

## Test plan
- Single requester: valid[2] with id=5, len=3 at cycle t → ready[2] at t. Beats at t+1..t+4 carry id=5, offsets 0,1,2,3, src=2, and last=1 only at offset 3.
- Fairness: all 8 requesters valid continuously with len=0 → grant order 0,1,2,…,7,0. Without the macro a beat appears every 2 cycles; with the macro a beat appears every cycle.
- Backpressure: len=7 burst with `io_out_ready` low for 3 cycles at offset 4 → offset holds at 4 with bits stable, then continues 5,6,7 with last only at 7.
- Wrap-around: after a grant to requester 6 (`ptr`=7), valid[1] and valid[7] → 7 is granted first, then 1.
- Reset mid-burst: `reset` low at offset 2 of a len=5 burst → `io_out_valid`=0 and all outputs 0 the next cycle. After release, valid[3] and valid[5] → 3 is granted.
- Macro defined: requester 0 (len=1) and requester 1 (len=1) both valid → four consecutive valid beats, offsets 0,1,0,1, src 0,0,1,1, with no idle cycle between bursts.
